keypad_scan_ctrl: RTL and testbench



---
 rtl/keypad_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
`timescale 1ns/1ps
// keypad_scan_ctrl: column-scanning 4x4 keypad controller.
// Drives one column low at a time, samples the synchronized rows, debounces a
// press, hands the encoded key {row, col} over a valid/ready handshake, then
// waits for a debounced release before scanning again.
// Optional build macro: KEYPAD_MULTIKEY_REJECT_EN (reject patterns with more
// than one row low; undefined by default, multi-row patterns accepted).
module keypad_scan_ctrl #(
    parameter int SCAN_DIV      = 16,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] filas_in,
    output logic [3:0] columnas_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready
);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_VALID    = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [15:0] STAB_LAST  = 16'(STABLE_CYCLES - 1);

    logic [3:0]  filasMeta_q;
    logic [3:0]  filasS_q;
    logic [1:0]  state_q,   state_d;
    logic [1:0]  colIdx_q,  colIdx_d;
    logic [1:0]  rowIdx_q,  rowIdx_d;
    logic [15:0] dwell_q,   dwell_d;
    logic [15:0] stab_q,    stab_d;
    logic [3:0]  pat_q,     pat_d;
    logic [3:0]  keyCode_q, keyCode_d;
    logic        sampleHit;

    // Index of the lowest-numbered row line pulled low.
    function automatic logic [1:0] lowZero(input logic [3:0] f);
        if (!f[0])      return 2'd0;
        else if (!f[1]) return 2'd1;
        else if (!f[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // True when more than one row line is low.
    function automatic logic multiZero(input logic [3:0] f);
        logic [3:0] z;
        z = ~f;
        return (z & (z - 4'd1)) != 4'd0;
    endfunction

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    assign sampleHit = (filasS_q != 4'hF) && !multiZero(filasS_q);
`else
    assign sampleHit = (filasS_q != 4'hF);
`endif

    assign columnas_out = ~(4'b0001 << colIdx_q);
    assign key_code     = keyCode_q;
    assign key_valid    = (state_q == ST_VALID);

    // Two-flop synchronizer for the asynchronous row lines, idles released.
    always_ff @(posedge clk) begin
        if (rst) begin
            filasMeta_q <= 4'hF;
            filasS_q    <= 4'hF;
        end else begin
            filasMeta_q <= filas_in;
            filasS_q    <= filasMeta_q;
        end
    end

    // Next-state logic for scan, debounce, handshake and release tracking.
    always_comb begin
        state_d   = state_q;
        colIdx_d  = colIdx_q;
        rowIdx_d  = rowIdx_q;
        dwell_d   = dwell_q;
        stab_d    = stab_q;
        pat_d     = pat_q;
        keyCode_d = keyCode_q;
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = 16'd0;
                    if (sampleHit) begin
                        pat_d    = filasS_q;
                        rowIdx_d = lowZero(filasS_q);
                        stab_d   = 16'd0;
                        state_d  = ST_DEBOUNCE;
                    end else begin
                        colIdx_d = colIdx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end
            ST_DEBOUNCE: begin
                if (filasS_q == pat_q) begin
                    if (stab_q == STAB_LAST) begin
                        state_d   = ST_VALID;
                        keyCode_d = {rowIdx_q, colIdx_q};
                        stab_d    = 16'd0;
                    end else begin
                        stab_d = stab_q + 16'd1;
                    end
                end else begin
                    state_d  = ST_SCAN;
                    colIdx_d = colIdx_q + 2'd1;
                    stab_d   = 16'd0;
                    dwell_d  = 16'd0;
                end
            end
            ST_VALID: begin
                if (key_ready) begin
                    state_d = ST_RELEASE;
                    stab_d  = 16'd0;
                end
            end
            ST_RELEASE: begin
                if (filasS_q == 4'hF) begin
                    if (stab_q == STAB_LAST) begin
                        state_d  = ST_SCAN;
                        colIdx_d = 2'd0;
                        dwell_d  = 16'd0;
                        stab_d   = 16'd0;
                    end else begin
                        stab_d = stab_q + 16'd1;
                    end
                end else begin
                    stab_d = 16'd0;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Controller state registers; reset discards any pending key.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SCAN;
            colIdx_q  <= 2'd0;
            rowIdx_q  <= 2'd0;
            dwell_q   <= 16'd0;
            stab_q    <= 16'd0;
            pat_q     <= 4'hF;
            keyCode_q <= 4'h0;
        end else begin
            state_q   <= state_d;
            colIdx_q  <= colIdx_d;
            rowIdx_q  <= rowIdx_d;
            dwell_q   <= dwell_d;
            stab_q    <= stab_d;
            pat_q     <= pat_d;
            keyCode_q <= keyCode_d;
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
`timescale 1ns/1ps
// tb_keypad_scan_ctrl: self-checking bench for keypad_scan_ctrl with
// SCAN_DIV=4, STABLE_CYCLES=8 and a behavioural keypad model.
module tb_keypad_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] filas_in;
    logic [3:0] columnas_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;

    bit         pressOn;
    logic [1:0] pressCol;
    logic [3:0] pressMask;

    int checks;
    int fails;
    int xfers;
    int k;
    logic [3:0] expQ[$];

    typedef struct {
        string      name;
        logic [1:0] col;
        logic [3:0] mask;
        bit         expectKey;
        logic [3:0] expCode;
    } vec_t;

    vec_t vecs[6];

    keypad_scan_ctrl #(
        .SCAN_DIV(4),
        .STABLE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .filas_in(filas_in),
        .columnas_out(columnas_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_ready(key_ready)
    );

    // Keypad model: pressed rows appear only while the key's column is driven.
    assign filas_in = (pressOn && (columnas_out[pressCol] == 1'b0)) ? pressMask : 4'hF;

    initial clk = 1'b0;
    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (k=%0d)", name, act, exp, k);
        end
    endtask

    // Advance to the next falling edge and score any handshake seen there.
    task automatic tick();
        logic [3:0] e;
        @(negedge clk);
        k++;
        if (!rst && key_valid && key_ready) begin
            xfers++;
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpected_xfer actual=%0h expected=none (k=%0d)", key_code, k);
            end else begin
                e = expQ.pop_front();
                checkOutput("xfer_code", {28'd0, key_code}, {28'd0, e});
            end
        end
    endtask

    // Reset, then stop at the falling edge of the first post-reset cycle (k=0).
    task automatic resetDut();
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        tick();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        k = 0;
    endtask

    task automatic waitXfers(input string name, input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (xfers >= target) break;
            tick();
        end
        checkOutput(name, xfers, target);
    endtask

    task automatic applyStimulus(input vec_t v);
        int base;
        pressCol  = v.col;
        pressMask = v.mask;
        pressOn   = 1'b1;
        key_ready = 1'b1;
        if (v.expectKey) expQ.push_back(v.expCode);
        base = xfers;
        resetDut();
        repeat (60) tick();
        checkOutput({v.name, "_xfers"}, xfers - base, v.expectKey ? 1 : 0);
        @(posedge clk);
        #1 pressOn = 1'b0;
        tick();
    endtask

    initial begin
        checks    = 0;
        fails     = 0;
        xfers     = 0;
        k         = 0;
        rst       = 1'b1;
        key_ready = 1'b1;
        pressOn   = 1'b0;
        pressCol  = 2'd0;
        pressMask = 4'hF;

        vecs[0] = '{"r0c0",  2'd0, 4'b1110, 1'b1, 4'h0};
        vecs[1] = '{"r2c1",  2'd1, 4'b1011, 1'b1, 4'h9};
        vecs[2] = '{"r3c3",  2'd3, 4'b0111, 1'b1, 4'hF};
        vecs[3] = '{"r1c2",  2'd2, 4'b1101, 1'b1, 4'h6};
        vecs[4] = '{"r3c0",  2'd0, 4'b0111, 1'b1, 4'hC};
`ifdef KEYPAD_MULTIKEY_REJECT_EN
        vecs[5] = '{"multi", 2'd2, 4'b0110, 1'b0, 4'h0};
`else
        vecs[5] = '{"multi", 2'd2, 4'b0110, 1'b1, 4'h2};
`endif

        // Reset values and idle column rotation.
        resetDut();
        checkOutput("rst_cols", {28'd0, columnas_out}, 32'hE);
        checkOutput("rst_valid", {31'd0, key_valid}, 0);
        checkOutput("rst_code", {28'd0, key_code}, 0);
        for (int j = 1; j < 20; j++) begin
            logic [3:0] expCols;
            tick();
            expCols = ~(4'b0001 << ((j / 4) % 4));
            checkOutput("idle_cols", {28'd0, columnas_out}, {28'd0, expCols});
            checkOutput("idle_valid", {31'd0, key_valid}, 0);
        end

        // Clean press row 2 / col 1 with ready high: exact latency and one pulse.
        pressCol  = 2'd1;
        pressMask = 4'b1011;
        pressOn   = 1'b1;
        key_ready = 1'b1;
        expQ.push_back(4'h9);
        resetDut();
        while (k < 8) tick();
        checkOutput("deb_col_held", {28'd0, columnas_out}, 32'hD);
        while (k < 15) tick();
        checkOutput("clean_valid_early", {31'd0, key_valid}, 0);
        tick();
        checkOutput("clean_valid_rise", {31'd0, key_valid}, 1);
        checkOutput("clean_code", {28'd0, key_code}, 32'h9);
        tick();
        checkOutput("clean_pulse_end", {31'd0, key_valid}, 0);
        repeat (24) tick();
        checkOutput("held_no_repeat", xfers, 1);
        @(posedge clk);
        #1 pressOn = 1'b0;
        repeat (20) tick();
        @(posedge clk);
        #1 pressOn = 1'b1;
        expQ.push_back(4'h9);
        tick();
        waitXfers("repress_xfer", 2, 100);
        @(posedge clk);
        #1 pressOn = 1'b0;
        tick();

        // Bouncing press: three short drop-outs early in debounce.
        expQ.push_back(4'h9);
        pressOn = 1'b1;
        resetDut();
        for (int j = 1; j <= 16; j++) begin
            @(posedge clk);
            #1 pressOn = !((j == 8) || (j == 10) || (j == 12));
            tick();
        end
        checkOutput("bounce_no_early_valid", {31'd0, key_valid}, 0);
        waitXfers("bounce_xfer", 3, 100);
        repeat (30) tick();
        checkOutput("bounce_single_xfer", xfers, 3);
        @(posedge clk);
        #1 pressOn = 1'b0;
        tick();

        // Consumer stalls 20 cycles: key held stable, then one transfer.
        key_ready = 1'b0;
        pressOn   = 1'b1;
        expQ.push_back(4'h9);
        resetDut();
        while (k < 16) tick();
        for (int j = 0; j < 20; j++) begin
            checkOutput("stall_valid", {31'd0, key_valid}, 1);
            checkOutput("stall_code", {28'd0, key_code}, 32'h9);
            if (j < 19) tick();
        end
        @(posedge clk);
        #1 key_ready = 1'b1;
        tick();
        checkOutput("stall_xfer", xfers, 4);
        tick();
        checkOutput("stall_valid_drop", {31'd0, key_valid}, 0);

        // Reset while a key is pending: discarded, scan restarts at column 0.
        key_ready = 1'b0;
        resetDut();
        while (k < 16) tick();
        checkOutput("pend_valid", {31'd0, key_valid}, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        checkOutput("midrst_valid", {31'd0, key_valid}, 0);
        checkOutput("midrst_code", {28'd0, key_code}, 0);
        checkOutput("midrst_cols", {28'd0, columnas_out}, 32'hE);
        repeat (4) tick();
        checkOutput("midrst_col1", {28'd0, columnas_out}, 32'hD);
        @(posedge clk);
        #1 pressOn = 1'b0;
        tick();
        checkOutput("midrst_no_xfer", xfers, 4);

        // Table of single and multi-row presses.
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        checkOutput("sb_empty", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
